serial_reg_master: RTL and testbench
====================================

Name: serial_reg_master

Overview:
- Host-side initiator for the byte-serial register protocol used by the capture board's command interface.
- Turns a parallel register-access request into the serial byte sequence:
  - Command byte `{1, W, addr[5:0]}`.
  - For writes, one data byte follows.
  - For reads, it collects the returned byte stream.
- Sits between a local controller (self-test sequencer or companion board) and an external UART transmitter/receiver pair.

Parameters:
- `TIMEOUT_CYCLES`, 1000000: maximum `clk` cycles to wait for each expected response byte.
- `TIMEOUT_W`, 20: width of the timeout counter. Must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.
- `LEN_W`, 16: width of the read-length request and the byte counter.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: request strobe; accepted only when `busy`=0.
- `cmd_write` in 1: 1=register write, 0=register read.
- `cmd_addr` in 6: register address.
- `cmd_wdata` in 8: write data.
- `cmd_rd_len` in LEN_W: bytes expected for a read; 0 is treated as 1.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse at the end of a transaction.
- `timeout` out 1: valid with `done`; 1 = read aborted because a byte failed to arrive.
- `rd_data` out 8: received byte.
- `rd_valid` out 1: one-cycle pulse per received byte.
- `rd_count` out LEN_W: bytes received in the current/last read.
- `tx_start` out 1: one-cycle pulse that launches a UART byte.
- `tx_data` out 8: byte to transmit; held stable from the `tx_start` cycle until the transmitter goes idle.
- `tx_busy` in 1: UART transmitter busy.
- `rx_ready` in 1: one-cycle pulse, received byte valid.
- `rx_data` in 8: received byte.

Behaviour:
- Reset: async, active-high.
  - State goes to IDLE.
  - All outputs go to 0: `busy`, `done`, `timeout`, `rd_valid`, `tx_start`, `tx_data`, `rd_data`, `rd_count`.
  - Reset mid-transaction abandons it; no `done` is issued.
- Request capture: in IDLE with `cmd_valid`=1, latch `cmd_write`, `cmd_addr`, `cmd_wdata` and `max(cmd_rd_len,1)`. Set `busy`=1 next cycle. `cmd_valid` while `busy`=1 is ignored.
- Command byte: `tx_data` = `{1'b1, cmd_write, cmd_addr}`; data byte = `cmd_wdata`.
- States:
  - IDLE: wait for `cmd_valid`.
    - Any `rx_ready` here is discarded.
  - SEND_CMD: when `tx_busy`=0, pulse `tx_start` with the command byte, then go to WAIT_CMD.
  - WAIT_CMD: ignore `tx_busy` for the first cycle (transmitter busy latency), then wait for `tx_busy`=0.
    - Write: go to SEND_DATA.
    - Read: clear `rd_count` and the timeout counter, then go to RECV.
  - SEND_DATA: when `tx_busy`=0, pulse `tx_start` with `cmd_wdata`, then go to WAIT_DATA.
  - WAIT_DATA: same 1-cycle ignore rule, then wait for `tx_busy`=0, then go to FINISH.
  - RECV: on each `rx_ready`:
    - Register `rx_data` into `rd_data` and pulse `rd_valid` the next cycle.
    - Increment `rd_count` and reset the timeout counter.
    - When `rd_count` reaches the latched length, go to FINISH.
    - Without `rx_ready`, the timeout counter increments. When it reaches `TIMEOUT_CYCLES`-1, set the timeout flag and go to FINISH.
  - FINISH: one cycle. `done`=1, `timeout` = flag, `busy` drops next cycle, return to IDLE.
    - `timeout` clears when the next request is accepted.
- Response byte timing in RECV: a byte arriving in the same cycle the timeout count expires is accepted and wins; the timeout is not flagged.
- Writes never wait for a response. The device returns nothing on writes.
- `rd_count` saturates at the latched length; excess `rx_ready` in IDLE is discarded.
- `tx_start` is never asserted while `tx_busy`=1.
- Latency, write with an idle transmitter: `tx_start` of the command byte 2 cycles after `cmd_valid`. `done` 1 cycle after `tx_busy` falls following the data byte.

Decomposition:
- Shared package/include:
  - State encodings: IDLE, SEND_CMD, WAIT_CMD, SEND_DATA, WAIT_DATA, RECV, FINISH.
  - Command-byte bit positions: `CMD_VALID_BIT`=7, `CMD_WRITE_BIT`=6.
  - Register address constants: GAIN=0, SETTINGS=1, STATUS=2, ADCDATA=3, ECHO=4, EXTFREQ 5-8, PHASE 9-10, DDRADDR 16-19.
- One natural sub-module: `serial_rx_timeout`, the per-byte timeout counter with clear/expire.
- The UART transmitter/receiver stay external.

Test Plan:
- Write ECHO: `cmd_write`=1, `addr`=4, `wdata`=0x5A -> tx bytes 0xC4 then 0x5A, `done`=1, `timeout`=0, no `rd_valid`.
- Read STATUS, `rd_len`=0: bench replies 0x03 -> tx byte 0x82, one `rd_valid` with `rd_data`=0x03, `rd_count`=1, `done`.
- Read ADCDATA, `rd_len`=4: replies 0x81,0x12,0x80,0x7F -> 4 `rd_valid` pulses in order, `done` after the 4th, `rd_count`=4.
- Read ECHO with no reply, `TIMEOUT_CYCLES`=100 -> tx byte 0x84; `done` with `timeout`=1 exactly 100 cycles after the end of the command byte; `rd_count`=0.
- Hold `tx_busy`=1 for 50 cycles at request time; pulse `cmd_valid` again while busy -> no `tx_start` until `tx_busy`=0, exactly one transaction executed.
- Assert `reset` during RECV of a 4-byte read after 2 bytes -> outputs 0 immediately, no `done`. A new write after reset completes normally.

Source files
------------

// File: rtl/serial_reg_master_pkg.sv
// Shared definitions for the byte-serial register protocol initiator:
// FSM state encoding, command-byte layout and the register address map.
package serial_reg_master_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    WAIT_CMD  = 3'd2,
    SEND_DATA = 3'd3,
    WAIT_DATA = 3'd4,
    RECV      = 3'd5,
    FINISH    = 3'd6
  } state_t;

  localparam int CMD_VALID_BIT = 7;
  localparam int CMD_WRITE_BIT = 6;

  localparam logic [5:0] REG_GAIN      = 6'd0;
  localparam logic [5:0] REG_SETTINGS  = 6'd1;
  localparam logic [5:0] REG_STATUS    = 6'd2;
  localparam logic [5:0] REG_ADCDATA   = 6'd3;
  localparam logic [5:0] REG_ECHO      = 6'd4;
  localparam logic [5:0] REG_EXTFREQ_0 = 6'd5;
  localparam logic [5:0] REG_EXTFREQ_1 = 6'd6;
  localparam logic [5:0] REG_EXTFREQ_2 = 6'd7;
  localparam logic [5:0] REG_EXTFREQ_3 = 6'd8;
  localparam logic [5:0] REG_PHASE_0   = 6'd9;
  localparam logic [5:0] REG_PHASE_1   = 6'd10;
  localparam logic [5:0] REG_DDRADDR_0 = 6'd16;
  localparam logic [5:0] REG_DDRADDR_1 = 6'd17;
  localparam logic [5:0] REG_DDRADDR_2 = 6'd18;
  localparam logic [5:0] REG_DDRADDR_3 = 6'd19;

  // Build the command byte: marker bit, write flag, 6-bit address.
  function automatic logic [7:0] cmd_byte(input logic write, input logic [5:0] addr);
    logic [7:0] b;
    b = {2'b00, addr};
    b[CMD_VALID_BIT] = 1'b1;
    b[CMD_WRITE_BIT] = write;
    return b;
  endfunction

endpackage

// File: rtl/serial_rx_timeout.sv
// Per-byte response timeout: counts idle cycles while a byte is awaited and
// flags expiry on the last allowed cycle. Cleared whenever a byte arrives.
module serial_rx_timeout #(
  parameter int unsigned LIMIT = 1000000,
  parameter int unsigned W     = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_r;

  // Idle-cycle counter; holds at the last value so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (run && (count_r != LAST)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/serial_reg_master.sv
// Host-side initiator for the byte-serial register protocol. Sends a command
// byte (plus a data byte for writes) through an external UART transmitter and
// collects the response byte stream for reads, with a per-byte timeout.
module serial_reg_master
  import serial_reg_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_W      = 20,
  parameter int unsigned LEN_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_write,
  input  logic [5:0]       cmd_addr,
  input  logic [7:0]       cmd_wdata,
  input  logic [LEN_W-1:0] cmd_rd_len,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [LEN_W-1:0] rd_count,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  input  logic             rx_ready,
  input  logic [7:0]       rx_data
);

  state_t           state_r, state_s;
  logic             write_r;
  logic [5:0]       addr_r;
  logic [7:0]       wdata_r;
  logic [LEN_W-1:0] len_r;
  logic             first_r, first_s;
  logic             capture_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             timeout_r, timeout_s;
  logic [7:0]       rd_data_r, rd_data_s;
  logic             rd_valid_r, rd_valid_s;
  logic [LEN_W-1:0] rd_count_r, rd_count_s, count_inc_s;
  logic             tx_start_r, tx_start_s;
  logic [7:0]       tx_data_r, tx_data_s;
  logic             tout_clear_s, tout_run_s, tout_expired_s;

  serial_rx_timeout #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TIMEOUT_W)
  ) u_rx_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tout_clear_s),
    .run     (tout_run_s),
    .expired (tout_expired_s)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s      = state_r;
    first_s      = 1'b0;
    capture_s    = 1'b0;
    timeout_s    = timeout_r;
    rd_data_s    = rd_data_r;
    rd_valid_s   = 1'b0;
    rd_count_s   = rd_count_r;
    tx_start_s   = 1'b0;
    tx_data_s    = tx_data_r;
    tout_clear_s = 1'b0;
    tout_run_s   = 1'b0;
    count_inc_s  = rd_count_r + LEN_W'(1);
    case (state_r)
      IDLE: begin
        // Stray response bytes are dropped here.
        if (cmd_valid) begin
          state_s   = SEND_CMD;
          capture_s = 1'b1;
          timeout_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      SEND_CMD: begin
        if (!tx_busy) begin
          tx_start_s = 1'b1;
          tx_data_s  = cmd_byte(write_r, addr_r);
          first_s    = 1'b1;
          state_s    = WAIT_CMD;
        end else begin
          state_s = SEND_CMD;
        end
      end
      WAIT_CMD: begin
        // First cycle after tx_start: transmitter has not raised busy yet.
        if (first_r) begin
          state_s = WAIT_CMD;
        end else if (!tx_busy) begin
          if (write_r) begin
            state_s = SEND_DATA;
          end else begin
            rd_count_s   = {LEN_W{1'b0}};
            tout_clear_s = 1'b1;
            state_s      = RECV;
          end
        end else begin
          state_s = WAIT_CMD;
        end
      end
      SEND_DATA: begin
        if (!tx_busy) begin
          tx_start_s = 1'b1;
          tx_data_s  = wdata_r;
          first_s    = 1'b1;
          state_s    = WAIT_DATA;
        end else begin
          state_s = SEND_DATA;
        end
      end
      WAIT_DATA: begin
        if (first_r) begin
          state_s = WAIT_DATA;
        end else if (!tx_busy) begin
          state_s = FINISH;
        end else begin
          state_s = WAIT_DATA;
        end
      end
      RECV: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (rx_ready) begin
          rd_data_s    = rx_data;
          rd_valid_s   = 1'b1;
          rd_count_s   = count_inc_s;
          tout_clear_s = 1'b1;
          if (count_inc_s >= len_r) begin
            state_s = FINISH;
          end else begin
            state_s = RECV;
          end
        end else if (tout_expired_s) begin
          timeout_s = 1'b1;
          state_s   = FINISH;
        end else begin
          tout_run_s = 1'b1;
          state_s    = RECV;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == FINISH);
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      first_r    <= 1'b0;
      write_r    <= 1'b0;
      addr_r     <= 6'd0;
      wdata_r    <= 8'd0;
      len_r      <= LEN_W'(1);
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
      rd_data_r  <= 8'd0;
      rd_valid_r <= 1'b0;
      rd_count_r <= {LEN_W{1'b0}};
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'd0;
    end else begin
      state_r    <= state_s;
      first_r    <= first_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      timeout_r  <= timeout_s;
      rd_data_r  <= rd_data_s;
      rd_valid_r <= rd_valid_s;
      rd_count_r <= rd_count_s;
      tx_start_r <= tx_start_s;
      tx_data_r  <= tx_data_s;
      if (capture_s) begin
        write_r <= cmd_write;
        addr_r  <= cmd_addr;
        wdata_r <= cmd_wdata;
        len_r   <= (cmd_rd_len == {LEN_W{1'b0}}) ? LEN_W'(1) : cmd_rd_len;
      end else begin
        write_r <= write_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
        len_r   <= len_r;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign timeout  = timeout_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign rd_count = rd_count_r;
  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;

endmodule

// File: tb/tb_serial_reg_master.sv
// Directed self-checking bench for serial_reg_master with a small UART
// transmitter model and a negedge output monitor.
module tb_serial_reg_master;
  import serial_reg_master_pkg::*;

  localparam int TO     = 100;
  localparam int TW     = 8;
  localparam int LW     = 16;
  localparam int TX_LEN = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [5:0]    cmd_addr = 6'd0;
  logic [7:0]    cmd_wdata = 8'd0;
  logic [LW-1:0] cmd_rd_len = 16'd0;
  logic          busy, done, timeout, rd_valid, tx_start;
  logic [7:0]    rd_data, tx_data;
  logic [LW-1:0] rd_count;
  logic          tx_busy;
  logic          tx_busy_model = 1'b0;
  logic          tx_hold = 1'b0;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data = 8'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] tx_log [64];
  logic [7:0] rv_log [64];
  int tx_cnt = 0, tx_done_cnt = 0, tx_drop_cyc = 0, tx_viol = 0, tx_left = 0;
  logic tx_arm = 1'b0;
  int rv_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic done_to = 1'b0;
  int b_tx, b_rv, b_dn, b_td;
  logic [7:0] exp3 [4];

  assign tx_busy = tx_busy_model | tx_hold;

  serial_reg_master #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_W      (TW),
    .LEN_W          (LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_rd_len (cmd_rd_len),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_count   (rd_count),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor and transmitter model: busy rises one cycle after tx_start.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        rv_log[rv_cnt & 63] = rd_data;
        rv_cnt++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        done_to  = timeout;
      end
      if (tx_start === 1'b1) begin
        if (tx_busy === 1'b1) tx_viol++;
        tx_log[tx_cnt & 63] = tx_data;
        tx_cnt++;
        tx_arm = 1'b1;
      end else if (tx_arm) begin
        tx_arm = 1'b0;
        tx_busy_model = 1'b1;
        tx_left = TX_LEN;
      end else if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) begin
          tx_busy_model = 1'b0;
          tx_drop_cyc = cyc;
          tx_done_cnt++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [5:0] a, input logic [7:0] d, input logic [LW-1:0] len);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_rd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev, input int budget);
    int n = 0;
    while (done_cnt == prev && n < budget) begin tick(); n++; end
    check(tag, done_cnt, prev + 1);
  endtask

  task automatic wait_tx_idle(input string tag, input int prev, input int budget);
    int n = 0;
    while (tx_done_cnt == prev && n < budget) begin tick(); n++; end
    check(tag, tx_done_cnt, prev + 1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_ready = 1'b1; rx_data = b;
    tick();
    rx_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_count"}, rd_count, 0);
  endtask

  initial begin
    exp3[0] = 8'h81; exp3[1] = 8'h12; exp3[2] = 8'h80; exp3[3] = 8'h7F;

    // Reset state
    tick(); tick(); tick();
    check_all_zero("rst");
    reset = 1'b0;
    tick(); tick();

    // Write ECHO 0x5A, with latency checks
    b_tx = tx_cnt; b_rv = rv_cnt; b_dn = done_cnt;
    issue(1'b1, REG_ECHO, 8'h5A, 16'd0);
    check("wr_busy_next", busy, 1);
    check("wr_no_start_yet", tx_start, 0);
    tick();
    check("wr_start_lat2", tx_start, 1);
    check("wr_cmd_byte_out", tx_data, 8'hC4);
    wait_done("wr_done", b_dn, 200);
    check("wr_tx_count", tx_cnt - b_tx, 2);
    check("wr_tx_byte0", tx_log[b_tx], 8'hC4);
    check("wr_tx_byte1", tx_log[b_tx + 1], 8'h5A);
    check("wr_timeout", done_to, 0);
    check("wr_no_rd_valid", rv_cnt - b_rv, 0);
    check("wr_done_lat", done_cyc - tx_drop_cyc, 1);
    check("wr_busy_drop", busy, 0);

    // Read STATUS, length 0 treated as 1
    b_tx = tx_cnt; b_rv = rv_cnt; b_dn = done_cnt; b_td = tx_done_cnt;
    issue(1'b0, REG_STATUS, 8'h00, 16'd0);
    wait_tx_idle("rs_tx_idle", b_td, 100);
    send_rx(8'h03);
    wait_done("rs_done", b_dn, 200);
    check("rs_tx_byte", tx_log[b_tx], 8'h82);
    check("rs_tx_count", tx_cnt - b_tx, 1);
    check("rs_rv_count", rv_cnt - b_rv, 1);
    check("rs_rd_data", rv_log[b_rv], 8'h03);
    check("rs_rd_count", rd_count, 1);
    check("rs_timeout", done_to, 0);

    // Stray byte in IDLE is discarded
    b_rv = rv_cnt;
    send_rx(8'hEE);
    check("idle_rx_rv", rv_cnt - b_rv, 0);
    check("idle_rx_count", rd_count, 1);

    // Read ADCDATA, 4 bytes
    b_tx = tx_cnt; b_rv = rv_cnt; b_dn = done_cnt; b_td = tx_done_cnt;
    issue(1'b0, REG_ADCDATA, 8'h00, 16'd4);
    wait_tx_idle("ad_tx_idle", b_td, 100);
    check("ad_tx_byte", tx_log[b_tx], 8'h83);
    send_rx(exp3[0]); send_rx(exp3[1]); send_rx(exp3[2]);
    check("ad_no_early_done", done_cnt - b_dn, 0);
    send_rx(exp3[3]);
    wait_done("ad_done", b_dn, 200);
    check("ad_rv_count", rv_cnt - b_rv, 4);
    for (int i = 0; i < 4; i++) check($sformatf("ad_byte%0d", i), rv_log[b_rv + i], exp3[i]);
    check("ad_rd_count", rd_count, 4);
    send_rx(8'h55);
    check("ad_saturate", rd_count, 4);
    check("ad_excess_rv", rv_cnt - b_rv, 4);

    // Read ECHO with no reply: timeout
    b_tx = tx_cnt; b_rv = rv_cnt; b_dn = done_cnt; b_td = tx_done_cnt;
    issue(1'b0, REG_ECHO, 8'h00, 16'd2);
    wait_tx_idle("to_tx_idle", b_td, 100);
    wait_done("to_done", b_dn, 300);
    check("to_tx_byte", tx_log[b_tx], 8'h84);
    check("to_flag", done_to, 1);
    check("to_flag_held", timeout, 1);
    check("to_rd_count", rd_count, 0);
    check("to_rv", rv_cnt - b_rv, 0);
    check("to_latency", done_cyc - (tx_drop_cyc + 1), 100);

    // Transmitter busy at request time; second request while busy ignored
    b_tx = tx_cnt; b_dn = done_cnt;
    tx_hold = 1'b1;
    issue(1'b1, REG_GAIN, 8'h11, 16'd0);
    check("hold_to_cleared", timeout, 0);
    repeat (5) tick();
    issue(1'b1, REG_SETTINGS, 8'h22, 16'd0);
    repeat (44) tick();
    check("hold_no_start", tx_cnt - b_tx, 0);
    check("hold_busy", busy, 1);
    tx_hold = 1'b0;
    wait_done("hold_done", b_dn, 200);
    check("hold_tx_count", tx_cnt - b_tx, 2);
    check("hold_byte0", tx_log[b_tx], 8'hC0);
    check("hold_byte1", tx_log[b_tx + 1], 8'h11);
    repeat (40) tick();
    check("hold_one_txn", done_cnt - b_dn, 1);
    check("hold_no_extra_tx", tx_cnt - b_tx, 2);

    // Reset in the middle of a 4-byte read
    b_tx = tx_cnt; b_rv = rv_cnt; b_dn = done_cnt; b_td = tx_done_cnt;
    issue(1'b0, REG_ADCDATA, 8'h00, 16'd4);
    wait_tx_idle("mr_tx_idle", b_td, 100);
    send_rx(8'hA1);
    send_rx(8'hB2);
    check("mr_rv_count", rv_cnt - b_rv, 2);
    check("mr_rd_count", rd_count, 2);
    reset = 1'b1;
    #1;
    check_all_zero("mr_rst");
    tick(); tick();
    reset = 1'b0;
    repeat (150) tick();
    check("mr_no_done", done_cnt - b_dn, 0);
    check("mr_idle", busy, 0);

    // Write after reset completes normally
    b_tx = tx_cnt; b_dn = done_cnt;
    issue(1'b1, REG_ECHO, 8'h5A, 16'd0);
    wait_done("pr_done", b_dn, 200);
    check("pr_tx_count", tx_cnt - b_tx, 2);
    check("pr_byte0", tx_log[b_tx], 8'hC4);
    check("pr_byte1", tx_log[b_tx + 1], 8'h5A);
    check("pr_timeout", done_to, 0);

    check("tx_start_while_busy", tx_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
